// File: rtl/rails_sequencer.sv
// rails_sequencer
//   Power-rail sequencer between the SPI register bank and the RAILS_* pins.
//   Ramps LP15V -> LP30V -> LP60V one rail per dwell period and ramps down in
//   reverse order. RAILS_OE (active-low) is asserted before the first rail
//   rises and released one dwell after the last rail falls. An external fault
//   (or, optionally, a heartbeat timeout) forces everything off.
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   target[2:0]    requested rails {60V,30V,15V}; nested into a level 0..3
//   fault_n        asynchronous external fault, active-low (2-flop synchronised)
//   kick           heartbeat pulse; only used with the watchdog build
//   rails_lp15v    LP15V enable
//   rails_lp30v    LP30V enable
//   rails_lp60v    LP60V enable
//   rails_oe       output enable, active-low
//   busy           high while sequencing (OE_SETUP/UP/DOWN/OE_HOLD)
//   fault_latched  high while in FAULT
//   state[2:0]     current state encoding for readback
//
// Build option
//   RAILS_SEQ_WATCHDOG_EN  adds a heartbeat watchdog of WDOG_CYCLES clocks that
//                          forces FAULT when rails are up and kick stops.
module rails_sequencer #(
  parameter int DWELL_CYCLES = 20000,
  parameter int WDOG_CYCLES  = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] target,
  input  logic       fault_n,
  input  logic       kick,
  output logic       rails_lp15v,
  output logic       rails_lp30v,
  output logic       rails_lp60v,
  output logic       rails_oe,
  output logic       busy,
  output logic       fault_latched,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_OE_SETUP = 3'd1,
    ST_UP       = 3'd2,
    ST_ON       = 3'd3,
    ST_DOWN     = 3'd4,
    ST_OE_HOLD  = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

  localparam int DCW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DCW-1:0] DWELL_LOAD = DCW'(DWELL_CYCLES - 1);

  state_t         state_reg;
  logic [2:0]     rails_reg;
  logic           oe_reg;
  logic [1:0]     cur_level_reg;
  logic [DCW-1:0] dwell_reg;
  logic [2:0]     target_reg;
  logic           fault_sync1_reg;
  logic           fault_sync2_reg;

  logic [1:0]     tgt_level;
  logic [2:0]     up_mask;
  logic [2:0]     dn_mask;
  logic           dwell_done;
  logic           wdog_fault;
  logic           fault_hit;

  // Higher rails only count when every lower rail is also requested.
  always_comb begin
    tgt_level = 2'd0;
    if (target_reg[0] && target_reg[1] && target_reg[2]) tgt_level = 2'd3;
    else if (target_reg[0] && target_reg[1])             tgt_level = 2'd2;
    else if (target_reg[0])                              tgt_level = 2'd1;
  end

  // up_mask selects the rail just above cur_level, dn_mask the highest rail on.
  always_comb begin
    up_mask = 3'b000;
    dn_mask = 3'b000;
    case (cur_level_reg)
      2'd0: up_mask = 3'b001;
      2'd1: begin up_mask = 3'b010; dn_mask = 3'b001; end
      2'd2: begin up_mask = 3'b100; dn_mask = 3'b010; end
      default: dn_mask = 3'b100;
    endcase
  end

  assign dwell_done = (dwell_reg == '0);

`ifdef RAILS_SEQ_WATCHDOG_EN
  localparam int WCW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WCW-1:0] WDOG_LOAD = WCW'(WDOG_CYCLES - 1);

  logic [WCW-1:0] wdog_reg;

  // Watchdog only runs while at least one rail is up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_reg <= '0;
    end else if (kick || (cur_level_reg == 2'd0)) begin
      wdog_reg <= WDOG_LOAD;
    end else if (wdog_reg != '0) begin
      wdog_reg <= wdog_reg - 1'b1;
    end
  end

  // Not gated by kick: a kick arriving on the expiry edge is too late.
  assign wdog_fault = (wdog_reg == '0) && (cur_level_reg != 2'd0);
`else
  logic unused_ok;
  assign unused_ok  = ^{kick, WDOG_CYCLES};
  assign wdog_fault = 1'b0;
`endif

  assign fault_hit = !fault_sync2_reg || wdog_fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_OFF;
      rails_reg       <= 3'b000;
      oe_reg          <= 1'b1;
      cur_level_reg   <= 2'd0;
      dwell_reg       <= '0;
      target_reg      <= 3'b000;
      fault_sync1_reg <= 1'b1;
      fault_sync2_reg <= 1'b1;
    end else begin
      fault_sync1_reg <= fault_n;
      fault_sync2_reg <= fault_sync1_reg;
      target_reg      <= target;

      if (state_reg == ST_FAULT) begin
        rails_reg     <= 3'b000;
        oe_reg        <= 1'b1;
        cur_level_reg <= 2'd0;
        dwell_reg     <= '0;
        // Leaving FAULT needs both a clean fault input and an explicit
        // all-off request, so rails cannot bounce straight back up.
        if (fault_sync2_reg && (target == 3'b000)) state_reg <= ST_OFF;
      end else if (fault_hit) begin
        rails_reg     <= 3'b000;
        oe_reg        <= 1'b1;
        cur_level_reg <= 2'd0;
        dwell_reg     <= '0;
        state_reg     <= ST_FAULT;
      end else begin
        case (state_reg)
          ST_OFF: begin
            rails_reg <= 3'b000;
            oe_reg    <= 1'b1;
            if (tgt_level != 2'd0) begin
              oe_reg    <= 1'b0;
              dwell_reg <= DWELL_LOAD;
              state_reg <= ST_OE_SETUP;
            end
          end
          ST_OE_SETUP: begin
            if (dwell_done) begin
              rails_reg     <= rails_reg | up_mask;
              cur_level_reg <= cur_level_reg + 2'd1;
              dwell_reg     <= DWELL_LOAD;
              state_reg     <= ST_UP;
            end else begin
              dwell_reg <= dwell_reg - 1'b1;
            end
          end
          ST_UP: begin
            if (dwell_done) begin
              if (tgt_level > cur_level_reg) begin
                rails_reg     <= rails_reg | up_mask;
                cur_level_reg <= cur_level_reg + 2'd1;
                dwell_reg     <= DWELL_LOAD;
              end else if (tgt_level < cur_level_reg) begin
                dwell_reg <= DWELL_LOAD;
                state_reg <= ST_DOWN;
              end else begin
                state_reg <= ST_ON;
              end
            end else begin
              dwell_reg <= dwell_reg - 1'b1;
            end
          end
          ST_ON: begin
            if (tgt_level > cur_level_reg) begin
              rails_reg     <= rails_reg | up_mask;
              cur_level_reg <= cur_level_reg + 2'd1;
              dwell_reg     <= DWELL_LOAD;
              state_reg     <= ST_UP;
            end else if (tgt_level < cur_level_reg) begin
              rails_reg     <= rails_reg & ~dn_mask;
              cur_level_reg <= cur_level_reg - 2'd1;
              dwell_reg     <= DWELL_LOAD;
              state_reg     <= ST_DOWN;
            end
          end
          ST_DOWN: begin
            if (dwell_done) begin
              dwell_reg <= DWELL_LOAD;
              if (cur_level_reg > tgt_level) begin
                rails_reg     <= rails_reg & ~dn_mask;
                cur_level_reg <= cur_level_reg - 2'd1;
                // Dropping the last rail starts the OE hold immediately so
                // OE releases one dwell after LP15V falls.
                if (cur_level_reg == 2'd1) state_reg <= ST_OE_HOLD;
              end else if (cur_level_reg == 2'd0) begin
                state_reg <= ST_OE_HOLD;
              end else if (tgt_level > cur_level_reg) begin
                state_reg <= ST_UP;
              end else begin
                state_reg <= ST_ON;
              end
            end else begin
              dwell_reg <= dwell_reg - 1'b1;
            end
          end
          ST_OE_HOLD: begin
            if (dwell_done) begin
              oe_reg    <= 1'b1;
              state_reg <= ST_OFF;
            end else begin
              dwell_reg <= dwell_reg - 1'b1;
            end
          end
          default: begin
            rails_reg     <= 3'b000;
            oe_reg        <= 1'b1;
            cur_level_reg <= 2'd0;
            state_reg     <= ST_FAULT;
          end
        endcase
      end
    end
  end

  assign rails_lp15v   = rails_reg[0];
  assign rails_lp30v   = rails_reg[1];
  assign rails_lp60v   = rails_reg[2];
  assign rails_oe      = oe_reg;
  assign state         = state_reg;
  assign busy          = (state_reg == ST_OE_SETUP) || (state_reg == ST_UP) ||
                         (state_reg == ST_DOWN)     || (state_reg == ST_OE_HOLD);
  assign fault_latched = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_rails_sequencer.sv
// Testbench for rails_sequencer with DWELL_CYCLES=4, WDOG_CYCLES=16.
module tb_rails_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] target = 3'b000;
  logic       fault_n = 1'b1;
  logic       kick = 1'b0;
  logic       rails_lp15v, rails_lp30v, rails_lp60v, rails_oe;
  logic       busy, fault_latched;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rails_sequencer #(.DWELL_CYCLES(4), .WDOG_CYCLES(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .target(target),
    .fault_n(fault_n),
    .kick(kick),
    .rails_lp15v(rails_lp15v),
    .rails_lp30v(rails_lp30v),
    .rails_lp60v(rails_lp60v),
    .rails_oe(rails_oe),
    .busy(busy),
    .fault_latched(fault_latched),
    .state(state)
  );

  typedef struct {
    string      name;
    logic [2:0] rails;
    logic       oe;
    logic [2:0] st;
    logic       busy;
    logic       flt;
  } exp_t;

  typedef struct {
    logic [2:0] tgt;
    logic       fn;
    int         n;
    logic [2:0] rails;
    logic       oe;
    logic [2:0] st;
    logic       busy;
    logic       flt;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic [2:0] r, input logic o,
                            input logic [2:0] s, input logic b, input logic f);
    exp_t e;
    e.name = nm; e.rails = r; e.oe = o; e.st = s; e.busy = b; e.flt = f;
    sb_q.push_back(e);
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_front();
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: got empty queue, required an entry");
    end else begin
      e = sb_q.pop_front();
      cmp({e.name, ".rails"}, {5'd0, rails_lp60v, rails_lp30v, rails_lp15v}, {5'd0, e.rails});
      cmp({e.name, ".oe"},    {7'd0, rails_oe},      {7'd0, e.oe});
      cmp({e.name, ".state"}, {5'd0, state},         {5'd0, e.st});
      cmp({e.name, ".busy"},  {7'd0, busy},          {7'd0, e.busy});
      cmp({e.name, ".fault"}, {7'd0, fault_latched}, {7'd0, e.flt});
      $display("[TB] %s tgt=%b fault_n=%b rails=%b oe=%b state=%0d busy=%b fl=%b",
               e.name, target, fault_n, {rails_lp60v, rails_lp30v, rails_lp15v},
               rails_oe, state, busy, fault_latched);
    end
  endtask

  // A rail must never be on while OE is deasserted.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      tests++;
      if (rails_oe && ({rails_lp60v, rails_lp30v, rails_lp15v} != 3'b000)) begin
        fails++;
        $display("FAIL rail_with_oe_high: got rails=%b oe=%b, required rails=000 while oe=1",
                 {rails_lp60v, rails_lp30v, rails_lp15v}, rails_oe);
      end
    end
  end

  initial begin
    // tgt, fault_n, edges, rails, oe, state, busy, fault
    vecs.push_back('{3'b111, 1'b1, 1, 3'b000, 1'b1, 3'd0, 1'b0, 1'b0}); // k: target captured
    vecs.push_back('{3'b111, 1'b1, 1, 3'b000, 1'b0, 3'd1, 1'b1, 1'b0}); // k+1: oe low
    vecs.push_back('{3'b111, 1'b1, 3, 3'b000, 1'b0, 3'd1, 1'b1, 1'b0}); // k+4
    vecs.push_back('{3'b111, 1'b1, 1, 3'b001, 1'b0, 3'd2, 1'b1, 1'b0}); // k+5: 15V
    vecs.push_back('{3'b111, 1'b1, 4, 3'b011, 1'b0, 3'd2, 1'b1, 1'b0}); // k+9: 30V
    vecs.push_back('{3'b111, 1'b1, 4, 3'b111, 1'b0, 3'd2, 1'b1, 1'b0}); // k+13: 60V
    vecs.push_back('{3'b111, 1'b1, 3, 3'b111, 1'b0, 3'd2, 1'b1, 1'b0}); // k+16
    vecs.push_back('{3'b111, 1'b1, 1, 3'b111, 1'b0, 3'd3, 1'b0, 1'b0}); // k+17: ON
    vecs.push_back('{3'b000, 1'b1, 1, 3'b111, 1'b0, 3'd3, 1'b0, 1'b0}); // j
    vecs.push_back('{3'b000, 1'b1, 1, 3'b011, 1'b0, 3'd4, 1'b1, 1'b0}); // j+1: 60V off
    vecs.push_back('{3'b000, 1'b1, 4, 3'b001, 1'b0, 3'd4, 1'b1, 1'b0}); // j+5: 30V off
    vecs.push_back('{3'b000, 1'b1, 4, 3'b000, 1'b0, 3'd5, 1'b1, 1'b0}); // j+9: 15V off
    vecs.push_back('{3'b000, 1'b1, 3, 3'b000, 1'b0, 3'd5, 1'b1, 1'b0}); // j+12
    vecs.push_back('{3'b000, 1'b1, 1, 3'b000, 1'b1, 3'd0, 1'b0, 1'b0}); // j+13: oe high
    vecs.push_back('{3'b101, 1'b1,10, 3'b001, 1'b0, 3'd3, 1'b0, 1'b0}); // nesting: level 1
    vecs.push_back('{3'b111, 1'b1, 2, 3'b011, 1'b0, 3'd2, 1'b1, 1'b0}); // ON->UP with 30V
    vecs.push_back('{3'b011, 1'b1, 2, 3'b011, 1'b0, 3'd2, 1'b1, 1'b0}); // mid-dwell change
    vecs.push_back('{3'b011, 1'b1, 2, 3'b011, 1'b0, 3'd3, 1'b0, 1'b0}); // no 60V, ON
    vecs.push_back('{3'b111, 1'b1, 6, 3'b111, 1'b0, 3'd3, 1'b0, 1'b0}); // up to level 3
    vecs.push_back('{3'b001, 1'b1, 2, 3'b011, 1'b0, 3'd4, 1'b1, 1'b0}); // level 2 in DOWN
    vecs.push_back('{3'b001, 1'b0, 2, 3'b011, 1'b0, 3'd4, 1'b1, 1'b0}); // fault in sync
    vecs.push_back('{3'b001, 1'b0, 1, 3'b000, 1'b1, 3'd6, 1'b0, 1'b1}); // reaction edge
    vecs.push_back('{3'b001, 1'b1, 4, 3'b000, 1'b1, 3'd6, 1'b0, 1'b1}); // held by target
    vecs.push_back('{3'b000, 1'b1, 1, 3'b000, 1'b1, 3'd0, 1'b0, 1'b0}); // exit to OFF

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_out("reset", 3'b000, 1'b1, 3'd0, 1'b0, 1'b0);
    check_front();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      target  = vecs[i].tgt;
      fault_n = vecs[i].fn;
      expect_out($sformatf("vec%0d", i), vecs[i].rails, vecs[i].oe, vecs[i].st,
                 vecs[i].busy, vecs[i].flt);
      run_edges(vecs[i].n);
      check_front();
    end

    // Fault arriving together with a power-up request from OFF.
    target  = 3'b111;
    fault_n = 1'b0;
    expect_out("offfault_k1", 3'b000, 1'b0, 3'd1, 1'b1, 1'b0);
    run_edges(2);
    check_front();
    expect_out("offfault_k2", 3'b000, 1'b1, 3'd6, 1'b0, 1'b1);
    run_edges(1);
    check_front();
    // Exit waits for the synchronised fault_n to clear.
    fault_n = 1'b1;
    target  = 3'b000;
    expect_out("offfault_sync", 3'b000, 1'b1, 3'd6, 1'b0, 1'b1);
    run_edges(2);
    check_front();
    expect_out("offfault_exit", 3'b000, 1'b1, 3'd0, 1'b0, 1'b0);
    run_edges(1);
    check_front();

`ifdef RAILS_SEQ_WATCHDOG_EN
    // No kick: 15V rises at e+5 (last reload), expiry fault at e+21.
    target = 3'b001;
    expect_out("wdog_on", 3'b001, 1'b0, 3'd3, 1'b0, 1'b0);
    run_edges(10);
    check_front();
    expect_out("wdog_pre", 3'b001, 1'b0, 3'd3, 1'b0, 1'b0);
    run_edges(11);
    check_front();
    expect_out("wdog_trip", 3'b000, 1'b1, 3'd6, 1'b0, 1'b1);
    run_edges(1);
    check_front();
    target = 3'b000;
    expect_out("wdog_clear", 3'b000, 1'b1, 3'd0, 1'b0, 1'b0);
    run_edges(1);
    check_front();
    // Regular kicks keep the rail up.
    target = 3'b001;
    expect_out("kick_on", 3'b001, 1'b0, 3'd3, 1'b0, 1'b0);
    run_edges(10);
    check_front();
    for (int p = 0; p < 5; p++) begin
      kick = 1'b1;
      run_edges(1);
      kick = 1'b0;
      expect_out($sformatf("kick%0d", p), 3'b001, 1'b0, 3'd3, 1'b0, 1'b0);
      run_edges(9);
      check_front();
    end
    target = 3'b000;
    run_edges(20);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
